// File: rtl/hamming_tx_sched.sv
// hamming_tx_sched: round-robin two-channel scheduler sharing one Hamming(12,8) encoder,
// serialising {start, channel, codeword, stop} frames at BIT_CYCLES clocks per bit.
module hamming (
    input  logic [7:0]  data,
    output logic [11:0] code
);
    assign code = {data,
                   ^{data[7], data[5], data[3], data[2]},
                   ^{data[7], data[6], data[4], data[2], data[1]},
                   ^{data[7], data[6], data[5], data[3], data[1], data[0]},
                   ^{data[6], data[4], data[3], data[0]}};
endmodule

module hamming_tx_sched #(
    parameter int BIT_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic       tx_bit,
    output logic       tx_busy,
    output logic       tx_chan,
    output logic       frame_done
);
    typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;
    localparam logic [15:0] LAST = 16'(BIT_CYCLES - 1);
    state_t      state;
    logic [7:0]  data_q;
    logic [14:0] shift_q;
    logic [3:0]  bit_cnt;
    logic [15:0] cyc_cnt;
    logic        last_grant;
    logic        grant;
    logic [11:0] code;
    hamming u_hamming (.data(data_q), .code(code));
    // on contention the channel not served last time wins
    assign grant      = (req0_valid & req1_valid) ? ~last_grant : req1_valid;
    assign req0_ready = (state == IDLE) & !rst & req0_valid & !grant;
    assign req1_ready = (state == IDLE) & !rst & req1_valid & grant;
    assign tx_busy    = (state != IDLE);
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            data_q     <= '0;
            shift_q    <= '1;
            bit_cnt    <= '0;
            cyc_cnt    <= '0;
            last_grant <= 1'b1;
            tx_bit     <= 1'b1;
            tx_chan    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: if (req0_ready | req1_ready) begin
                    data_q     <= grant ? req1_data : req0_data;
                    tx_chan    <= grant;
                    last_grant <= grant;
                    state      <= LOAD;
                end
                LOAD: begin
                    shift_q <= {1'b0, tx_chan, code, 1'b1};
                    bit_cnt <= '0;
                    cyc_cnt <= '0;
                    tx_bit  <= 1'b0;
                    state   <= SEND;
                end
                SEND: if (cyc_cnt == LAST) begin
                    cyc_cnt <= '0;
                    shift_q <= {shift_q[13:0], 1'b1};
                    bit_cnt <= bit_cnt + 4'd1;
                    tx_bit  <= shift_q[13];
                    if (bit_cnt == 4'd14) begin
                        state      <= IDLE;
                        bit_cnt    <= '0;
                        tx_bit     <= 1'b1;
                        frame_done <= 1'b1;
                    end
                end else begin
                    cyc_cnt <= cyc_cnt + 16'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
